// File: rtl/udp_arb_pkg.sv
// Shared types and constants for the UDP ingress arbiter.
package udp_arb_pkg;

   localparam int AXIS_DATA_W   = 32;
   localparam int ARB_MAX_PORTS = 16;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/udp_ingress_arbiter_rr_pick.sv
// Wrap-around priority search: first requester strictly after 'last',
// moving upward and wrapping modulo NUM_PORTS. Purely combinational.
module rr_pick
   import udp_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PORT_W-1:0]    last,
   output logic [PORT_W-1:0]    pick,
   output logic                 any
);

   // Scan from the farthest candidate down to last+1 so the nearest requester wins.
   always_comb begin
      pick = '0;
      any  = |req;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         if (req[(int'(last) + i) % NUM_PORTS]) begin
            pick = PORT_W'((int'(last) + i) % NUM_PORTS);
         end
      end
   end

endmodule

// File: rtl/udp_ingress_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream ingress lanes
// into one registered output stream tagged with the source port.
// Optional per-port completed-packet counters: define UDP_ARB_PKT_CNT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ARB_IDLE | no grant held; pick next requester after last_grant
// ARB_BUSY | grant held on port 'grant' until its tlast beat is accepted
module udp_ingress_arbiter
   import udp_arb_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   localparam int PORT_W    = $clog2(NUM_PORTS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS*AXIS_DATA_W-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]             s_axis_tlast,
   output logic [NUM_PORTS-1:0]             s_axis_tready,
   output logic [AXIS_DATA_W-1:0]           m_axis_tdata,
   output logic                             m_axis_tvalid,
   output logic                             m_axis_tlast,
   output logic [PORT_W-1:0]                m_axis_tid,
   input  logic                             m_axis_tready
`ifdef UDP_ARB_PKT_CNT_EN
   ,
   output logic [NUM_PORTS*32-1:0]          pkt_cnt
`endif
);

   if (NUM_PORTS < 2 || NUM_PORTS > ARB_MAX_PORTS) begin : g_bad_num_ports
      $error("udp_ingress_arbiter: NUM_PORTS out of range");
   end

   arb_state_e              state_q, state_d;
   logic [PORT_W-1:0]       grant_q, grant_d;
   logic [PORT_W-1:0]       last_grant_q, last_grant_d;
   logic [AXIS_DATA_W-1:0]  m_data_q, m_data_d;
   logic                    m_valid_q, m_valid_d;
   logic                    m_last_q, m_last_d;
   logic [PORT_W-1:0]       m_tid_q, m_tid_d;

   logic [PORT_W-1:0]       pick;
   logic                    any_req;
   logic                    out_free;
   logic                    accept;
   logic                    beat_last;
   logic [AXIS_DATA_W-1:0]  beat_data;

   rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
   ) u_rr_pick (
      .req  (s_axis_tvalid),
      .last (last_grant_q),
      .pick (pick),
      .any  (any_req)
   );

   // Output slot can take a beat when empty or being drained this cycle.
   assign out_free  = !m_valid_q || m_axis_tready;
   assign beat_last = s_axis_tlast[grant_q];
   assign beat_data = s_axis_tdata[grant_q*AXIS_DATA_W +: AXIS_DATA_W];
   assign accept    = (state_q == ARB_BUSY) && s_axis_tvalid[grant_q] && out_free;

   // Only the granted port sees ready, and only while busy.
   always_comb begin
      s_axis_tready = '0;
      if (state_q == ARB_BUSY) begin
         s_axis_tready[grant_q] = out_free;
      end
   end

   // Next-state: grant on any request, release after the tlast beat.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ARB_IDLE: begin
            if (any_req) begin
               grant_d = pick;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (accept && beat_last) begin
               last_grant_d = grant_q;
               state_d      = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Output register: load on accept, empty when drained, else hold.
   always_comb begin
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_tid_d   = m_tid_q;
      if (accept) begin
         m_data_d  = beat_data;
         m_last_d  = beat_last;
         m_tid_d   = grant_q;
         m_valid_d = 1'b1;
      end else if (m_axis_tready) begin
         m_valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         grant_q      <= '0;
         last_grant_q <= '0;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         m_tid_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         m_tid_q      <= m_tid_d;
      end
   end

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tid    = m_tid_q;

`ifdef UDP_ARB_PKT_CNT_EN
   logic [NUM_PORTS*32-1:0] cnt_q, cnt_d;

   // Count a completed packet on its accepted tlast beat; wraps naturally.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && beat_last) begin
         cnt_d[grant_q*32 +: 32] = cnt_q[grant_q*32 +: 32] + 32'd1;
      end
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_udp_ingress_arbiter.sv
// Directed self-checking bench for udp_ingress_arbiter (NUM_PORTS = 4).
module tb_udp_ingress_arbiter;

   localparam int N = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  tid;
      logic        last;
      logic [31:0] data;
   } obs_t;

   logic            clk;
   logic            rst_n;
   logic [N*32-1:0] s_axis_tdata;
   logic [N-1:0]    s_axis_tvalid;
   logic [N-1:0]    s_axis_tlast;
   logic [N-1:0]    s_axis_tready;
   logic [31:0]     m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tlast;
   logic [1:0]      m_axis_tid;
   logic            m_axis_tready;
`ifdef UDP_ARB_PKT_CNT_EN
   logic [N*32-1:0] pkt_cnt;
`endif

   beat_t src_q [N][$];
   obs_t  obs_q [$];
   obs_t  acc_q [$];
   int    cyc;
   int    vectors;
   int    miscompares;

   udp_ingress_arbiter #(.NUM_PORTS(N)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tready (m_axis_tready)
`ifdef UDP_ARB_PKT_CNT_EN
      ,
      .pkt_cnt       (pkt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present each source queue head; idle ports show junk with tlast set.
   task automatic drive_src();
      for (int p = 0; p < N; p++) begin
         if (src_q[p].size() > 0) begin
            s_axis_tvalid[p]         = 1'b1;
            s_axis_tdata[p*32 +: 32] = src_q[p][0].data;
            s_axis_tlast[p]          = src_q[p][0].last;
         end else begin
            s_axis_tvalid[p]         = 1'b0;
            s_axis_tdata[p*32 +: 32] = 32'h0BAD_0000 | 32'(p);
            s_axis_tlast[p]          = 1'b1;
         end
      end
   endtask

   // One clock: sample handshakes before the edge, update sources after it.
   task automatic cycle();
      logic [N-1:0] fired;
      obs_t         o;
      #1;
      for (int p = 0; p < N; p++) begin
         fired[p] = s_axis_tvalid[p] && s_axis_tready[p];
         if (fired[p]) begin
            o.cyc  = 32'(cyc);
            o.tid  = 2'(p);
            o.last = s_axis_tlast[p];
            o.data = s_axis_tdata[p*32 +: 32];
            acc_q.push_back(o);
         end
      end
      if (m_axis_tvalid && m_axis_tready) begin
         o.cyc  = 32'(cyc);
         o.tid  = m_axis_tid;
         o.last = m_axis_tlast;
         o.data = m_axis_tdata;
         obs_q.push_back(o);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < N; p++) begin
         if (fired[p]) void'(src_q[p].pop_front());
      end
      drive_src();
   endtask

   function automatic bit src_busy();
      for (int p = 0; p < N; p++) begin
         if (src_q[p].size() > 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((src_busy() || m_axis_tvalid) && n < budget) begin
         cycle();
         n++;
      end
      vectors++;
      if (src_busy() || m_axis_tvalid) begin
         miscompares++;
         $display("FAIL %s_drain: still busy after %0d cycles, need idle", name, budget);
      end
   endtask

   task automatic wait_acc(input string name, input int k, input int budget);
      int n = 0;
      while (acc_q.size() < k && n < budget) begin
         cycle();
         n++;
      end
      vectors++;
      if (acc_q.size() < k) begin
         miscompares++;
         $display("FAIL %s_wait: %0d beats accepted, need %0d", name, acc_q.size(), k);
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      m_axis_tready = 1'b1;
      for (int p = 0; p < N; p++) src_q[p].delete();
      drive_src();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc   = 0;
      obs_q.delete();
      acc_q.delete();
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      m_axis_tready = 1'b1;
      s_axis_tvalid = '1;
      s_axis_tlast  = '1;
      s_axis_tdata  = {N{32'hFFFF_FFFF}};
      @(posedge clk); #1;
      @(posedge clk); #1;
      vectors += 5;
      if (m_axis_tdata !== 32'h0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
      if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
      if (m_axis_tlast !== 1'b0)  begin miscompares++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
      if (m_axis_tid !== 2'd0)    begin miscompares++; $display("FAIL reset_tid: got %0d want 0", m_axis_tid); end
      if (s_axis_tready !== 4'h0) begin miscompares++; $display("FAIL reset_sready: got %b want 0000", s_axis_tready); end
   endtask

   task automatic test_single();
      int c0;
      do_reset();
      for (int b = 1; b <= 3; b++) src_q[2].push_back('{data: 32'hA000_0000 | 32'(b), last: (b == 3)});
      c0 = cyc;
      drive_src();
      drain("single", 30);
      vectors++;
      if (obs_q.size() !== 3 || acc_q.size() !== 3) begin
         miscompares++;
         $display("FAIL single_count: got %0d out/%0d in beats, want 3/3", obs_q.size(), acc_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors += 3;
            if (obs_q[i].data !== (32'hA000_0001 + 32'(i))) begin miscompares++; $display("FAIL single_data[%0d]: got %h want %h", i, obs_q[i].data, 32'hA000_0001 + 32'(i)); end
            if (obs_q[i].tid !== 2'd2) begin miscompares++; $display("FAIL single_tid[%0d]: got %0d want 2", i, obs_q[i].tid); end
            if (obs_q[i].last !== (i == 2)) begin miscompares++; $display("FAIL single_last[%0d]: got %b want %b", i, obs_q[i].last, (i == 2)); end
         end
         vectors += 3;
         if (acc_q[0].cyc !== 32'(c0 + 1)) begin miscompares++; $display("FAIL single_arb_lat: first accept cycle %0d want %0d", acc_q[0].cyc, c0 + 1); end
         if (obs_q[0].cyc !== acc_q[0].cyc + 1) begin miscompares++; $display("FAIL single_out_lat: first output cycle %0d want %0d", obs_q[0].cyc, acc_q[0].cyc + 1); end
         if (obs_q[2].cyc !== obs_q[0].cyc + 2) begin miscompares++; $display("FAIL single_rate: third output cycle %0d want %0d", obs_q[2].cyc, obs_q[0].cyc + 2); end
      end
   endtask

   task automatic test_all_req();
      int          ord [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
      int          p, k, b;
      logic [31:0] exp_d;
      do_reset();
      for (int kk = 0; kk < 2; kk++) begin
         for (int pp = 0; pp < N; pp++) begin
            src_q[pp].push_back('{data: 32'hB000_0000 | 32'(pp << 8) | 32'(kk << 4), last: 1'b0});
            src_q[pp].push_back('{data: 32'hB000_0001 | 32'(pp << 8) | 32'(kk << 4), last: 1'b1});
         end
      end
      drive_src();
      drain("allreq", 100);
      vectors++;
      if (obs_q.size() !== 16) begin
         miscompares++;
         $display("FAIL allreq_count: got %0d beats want 16", obs_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            p     = ord[i / 2];
            k     = i / 8;
            b     = i % 2;
            exp_d = 32'hB000_0000 | 32'(p << 8) | 32'(k << 4) | 32'(b);
            vectors += 4;
            if (obs_q[i].tid !== 2'(p)) begin miscompares++; $display("FAIL allreq_tid[%0d]: got %0d want %0d", i, obs_q[i].tid, p); end
            if (obs_q[i].data !== exp_d) begin miscompares++; $display("FAIL allreq_data[%0d]: got %h want %h", i, obs_q[i].data, exp_d); end
            if (obs_q[i].last !== (b == 1)) begin miscompares++; $display("FAIL allreq_last[%0d]: got %b want %b", i, obs_q[i].last, (b == 1)); end
            if (i > 0 && obs_q[i].cyc !== obs_q[i-1].cyc + ((b == 1) ? 32'd1 : 32'd2)) begin
               miscompares++;
               $display("FAIL allreq_gap[%0d]: cycle %0d want %0d", i, obs_q[i].cyc, obs_q[i-1].cyc + ((b == 1) ? 32'd1 : 32'd2));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int b = 1; b <= 4; b++) src_q[0].push_back('{data: 32'hC000_0000 | 32'(b), last: (b == 4)});
      drive_src();
      wait_acc("bp", 2, 20);
      m_axis_tready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         vectors += 3;
         if (m_axis_tdata !== 32'hC000_0002) begin miscompares++; $display("FAIL bp_hold_data[%0d]: got %h want c0000002", i, m_axis_tdata); end
         if (m_axis_tvalid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, m_axis_tvalid); end
         if (s_axis_tready !== 4'h0) begin miscompares++; $display("FAIL bp_sready[%0d]: got %b want 0000", i, s_axis_tready); end
         cycle();
      end
      m_axis_tready = 1'b1;
      drain("bp", 30);
      vectors++;
      if (obs_q.size() !== 4) begin
         miscompares++;
         $display("FAIL bp_count: got %0d beats want 4", obs_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors += 2;
            if (obs_q[i].data !== (32'hC000_0001 + 32'(i))) begin miscompares++; $display("FAIL bp_data[%0d]: got %h want %h", i, obs_q[i].data, 32'hC000_0001 + 32'(i)); end
            if (obs_q[i].last !== (i == 3)) begin miscompares++; $display("FAIL bp_last[%0d]: got %b want %b", i, obs_q[i].last, (i == 3)); end
         end
      end
   endtask

   task automatic test_wrap();
      logic [1:0]  exp_tid [4] = '{2'd0, 2'd3, 2'd0, 2'd3};
      logic [31:0] exp_d   [4] = '{32'hF000_0010, 32'hF000_0030, 32'hF000_0011, 32'hF000_0031};
      do_reset();
      src_q[3].push_back('{data: 32'hF000_0003, last: 1'b1});
      drive_src();
      drain("wrap_pre", 20);
      obs_q.delete();
      acc_q.delete();
      src_q[0].push_back('{data: 32'hF000_0010, last: 1'b1});
      src_q[0].push_back('{data: 32'hF000_0011, last: 1'b1});
      src_q[3].push_back('{data: 32'hF000_0030, last: 1'b1});
      src_q[3].push_back('{data: 32'hF000_0031, last: 1'b1});
      drive_src();
      drain("wrap", 40);
      vectors++;
      if (obs_q.size() !== 4) begin
         miscompares++;
         $display("FAIL wrap_count: got %0d beats want 4", obs_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors += 3;
            if (obs_q[i].tid !== exp_tid[i]) begin miscompares++; $display("FAIL wrap_tid[%0d]: got %0d want %0d", i, obs_q[i].tid, exp_tid[i]); end
            if (obs_q[i].data !== exp_d[i]) begin miscompares++; $display("FAIL wrap_data[%0d]: got %h want %h", i, obs_q[i].data, exp_d[i]); end
            if (obs_q[i].last !== 1'b1) begin miscompares++; $display("FAIL wrap_last[%0d]: got %b want 1", i, obs_q[i].last); end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int b = 1; b <= 4; b++) src_q[1].push_back('{data: 32'hD000_0000 | 32'(b), last: (b == 4)});
      drive_src();
      wait_acc("rstmid", 2, 20);
      rst_n = 1'b0;
      #1;
      vectors += 5;
      if (m_axis_tdata !== 32'h0) begin miscompares++; $display("FAIL rstmid_tdata: got %h want 0", m_axis_tdata); end
      if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_tvalid: got %b want 0", m_axis_tvalid); end
      if (m_axis_tlast !== 1'b0)  begin miscompares++; $display("FAIL rstmid_tlast: got %b want 0", m_axis_tlast); end
      if (m_axis_tid !== 2'd0)    begin miscompares++; $display("FAIL rstmid_tid: got %0d want 0", m_axis_tid); end
      if (s_axis_tready !== 4'h0) begin miscompares++; $display("FAIL rstmid_sready: got %b want 0000", s_axis_tready); end
      for (int p = 0; p < N; p++) src_q[p].delete();
      drive_src();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      obs_q.delete();
      acc_q.delete();
      src_q[2].push_back('{data: 32'hE000_0001, last: 1'b0});
      src_q[2].push_back('{data: 32'hE000_0002, last: 1'b1});
      drive_src();
      drain("rstmid", 30);
      vectors++;
      if (obs_q.size() !== 2) begin
         miscompares++;
         $display("FAIL rstmid_count: got %0d beats want 2", obs_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            vectors += 3;
            if (obs_q[i].data !== (32'hE000_0001 + 32'(i))) begin miscompares++; $display("FAIL rstmid_data[%0d]: got %h want %h", i, obs_q[i].data, 32'hE000_0001 + 32'(i)); end
            if (obs_q[i].tid !== 2'd2) begin miscompares++; $display("FAIL rstmid_tid2[%0d]: got %0d want 2", i, obs_q[i].tid); end
            if (obs_q[i].last !== (i == 1)) begin miscompares++; $display("FAIL rstmid_last[%0d]: got %b want %b", i, obs_q[i].last, (i == 1)); end
         end
      end
   endtask

`ifdef UDP_ARB_PKT_CNT_EN
   task automatic test_pkt_cnt();
      logic [31:0] exp_c [4] = '{32'd3, 32'd0, 32'd0, 32'd1};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         src_q[0].push_back('{data: 32'h1100_0000 | 32'(k), last: 1'b0});
         src_q[0].push_back('{data: 32'h1100_0010 | 32'(k), last: 1'b1});
      end
      src_q[3].push_back('{data: 32'h1300_0000, last: 1'b1});
      drive_src();
      drain("cnt", 60);
      for (int p = 0; p < N; p++) begin
         vectors++;
         if (pkt_cnt[p*32 +: 32] !== exp_c[p]) begin miscompares++; $display("FAIL cnt_port%0d: got %0d want %0d", p, pkt_cnt[p*32 +: 32], exp_c[p]); end
      end
      force dut.cnt_q = {32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF};
      @(posedge clk); #1;
      release dut.cnt_q;
      src_q[0].push_back('{data: 32'h1100_0099, last: 1'b1});
      drive_src();
      drain("cnt_wrap", 20);
      vectors += 2;
      if (pkt_cnt[31:0] !== 32'd0) begin miscompares++; $display("FAIL cnt_wrap_port0: got %h want 0", pkt_cnt[31:0]); end
      if (pkt_cnt[127:96] !== 32'd1) begin miscompares++; $display("FAIL cnt_wrap_port3: got %0d want 1", pkt_cnt[127:96]); end
   endtask
`endif

   initial begin
      vectors       = 0;
      miscompares   = 0;
      cyc           = 0;
      rst_n         = 1'b0;
      m_axis_tready = 1'b1;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      s_axis_tdata  = '0;
      test_reset();
      test_single();
      test_all_req();
      test_backpressure();
      test_wrap();
      test_reset_mid();
`ifdef UDP_ARB_PKT_CNT_EN
      test_pkt_cnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
